// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the downstream FIFO write port.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cycles counter output.
//
// state | meaning
// IDLE  | no grant held; round-robin search from last_grant+1
// GRANT | grant_id owns the FIFO write port for up to MAX_BURST beats
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]         stall_cycles,
`endif
  fifo_wr_arbiter_if.slave    bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic             grant_valid_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] beat_cnt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  cand;
  logic             cur_valid;
  logic             accept;

  // Scan from farthest to nearest so the nearest candidate after last_grant wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign cur_valid = bus.req_valid[grant_id_q];
  assign accept    = (state == GRANT) && cur_valid && !bus.fifo_full && !rst;

  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_data_in = bus.req_data[grant_id_q*WIDTH +: WIDTH];
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_id     = grant_id_q;

  always_comb begin
    bus.req_ready             = '0;
    bus.req_ready[grant_id_q] = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant    <= ID_W'(NUM_REQ - 1);
      beat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state         <= GRANT;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_id;
            last_grant    <= pick_id;
            beat_cnt      <= '0;
          end
        end
        GRANT: begin
          // Dropping valid forfeits the grant; a full FIFO just holds it.
          if (!cur_valid) begin
            state         <= IDLE;
            grant_valid_q <= 1'b0;
          end else if (accept) begin
            if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
              state         <= IDLE;
              grant_valid_q <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == GRANT) && cur_valid && bus.fifo_full && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cycles;
`endif

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIFO_ARB_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  typedef struct {
    logic         gv;
    logic [1:0]   gid;
    logic [N-1:0] ready;
    logic         wr;
    logic [15:0]  stall;
  } status_t;

  typedef struct {
    int         id;
    logic [W-1:0] data;
  } beat_t;

  status_t st_q[$];
  beat_t   bt_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner is the requester holding the port (-1 = none), beats counts its accepted beats.
  int m_owner, m_last, m_beats, m_gid, m_stall;

  logic [W-1:0] d_cur [N];
  logic [N-1:0] v_cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
    m_gid   = 0;
    m_stall = 0;
  endtask

  task automatic drive_cycle(input logic [N-1:0] v, input logic full, input logic r, output int acc);
    status_t s;
    beat_t   b;
    bus.req_valid = v;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = d_cur[i];
    bus.fifo_full = full;
    rst = r;

    acc = -1;
    if (!r && m_owner >= 0 && v[m_owner] && !full) acc = m_owner;
    s.gv    = (m_owner >= 0);
    s.gid   = 2'(m_gid);
    s.ready = (acc >= 0) ? N'(1 << acc) : '0;
    s.wr    = (acc >= 0);
    s.stall = 16'(m_stall);
    st_q.push_back(s);
    if (acc >= 0) begin
      b.id   = acc;
      b.data = d_cur[acc];
      bt_q.push_back(b);
    end

    if (r) begin
      model_reset();
    end else begin
      if (m_owner >= 0 && v[m_owner] && full && m_stall < 65535) m_stall++;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (v[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            m_last  = m_owner;
            m_gid   = m_owner;
            m_beats = 0;
            break;
          end
        end
      end else if (!v[m_owner]) begin
        m_owner = -1;
      end else if (acc >= 0) begin
        m_beats++;
        if (m_beats == MB) m_owner = -1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: one status entry per cycle; a beat is popped whenever the DUT writes.
  always @(negedge clk) begin
    status_t s;
    beat_t   b;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("grant_valid", 32'(bus.grant_valid), 32'(s.gv));
      chk("grant_id", 32'(bus.grant_id), 32'(s.gid));
      chk("req_ready", 32'(bus.req_ready), 32'(s.ready));
      chk("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(s.wr));
`ifdef FIFO_ARB_STATS_EN
      chk("stall_cycles", 32'(stall_cycles), 32'(s.stall));
`endif
    end
    if (bus.fifo_wr_en === 1'b1) begin
      if (bt_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.fifo_data_in), 32'hFFFF_FFFF);
      end else begin
        b = bt_q.pop_front();
        chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(b.data));
        chk("writer_id", 32'(bus.req_ready), 32'(1 << b.id));
      end
    end
  end

  initial begin
    int acc;
    int cnt;
    int left;
    logic r;
    logic full;
    logic [W-1:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hA2; vals[2] = 8'hA3;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) d_cur[i] = 8'($urandom);
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with every requester valid.
    for (int c = 0; c < 2; c++) drive_cycle('1, 1'b0, 1'b1, acc);

    // Fairness: all requesters continuously valid.
    for (int c = 0; c < 22; c++) begin
      drive_cycle('1, 1'b0, 1'b0, acc);
      if (acc >= 0) d_cur[acc] = 8'($urandom);
    end
    for (int c = 0; c < 3; c++) drive_cycle('0, 1'b0, 1'b0, acc);

    // Single requester 2 streaming A1, A2, A3.
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      d_cur[2] = vals[cnt];
      drive_cycle(4'b0100, 1'b0, 1'b0, acc);
      if (acc == 2) cnt++;
    end
    for (int c = 0; c < 3; c++) drive_cycle('0, 1'b0, 1'b0, acc);

    // Backpressure: full for 3 cycles after beat 2.
    cnt = 0;
    left = 3;
    for (int c = 0; c < 15 && cnt < 4; c++) begin
      full = (cnt == 2 && left > 0);
      drive_cycle(4'b0001, full, 1'b0, acc);
      if (full) left--;
      if (acc >= 0) begin
        cnt++;
        d_cur[0] = 8'($urandom);
      end
    end
    for (int c = 0; c < 3; c++) drive_cycle('0, 1'b0, 1'b0, acc);

    // Early release: requester 1 drops valid after 2 beats, requester 3 waiting.
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle((cnt < 2) ? 4'b1010 : 4'b1000, 1'b0, 1'b0, acc);
      if (acc >= 0) d_cur[acc] = 8'($urandom);
      if (acc == 1) cnt++;
    end
    for (int c = 0; c < 3; c++) drive_cycle('0, 1'b0, 1'b0, acc);

    // Mid-burst reset on beat 2, then all valid.
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      r = (cnt == 1);
      drive_cycle(4'b0100, 1'b0, r, acc);
      if (acc == 2) begin
        cnt++;
        d_cur[2] = 8'($urandom);
      end
      if (r) break;
    end
    for (int c = 0; c < 4; c++) begin
      drive_cycle('1, 1'b0, 1'b0, acc);
      if (acc >= 0) d_cur[acc] = 8'($urandom);
    end

    // Random traffic.
    v_cur = '0;
    acc = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (v_cur[i] && acc != i) begin
          if ($urandom_range(19, 0) == 0) v_cur[i] = 1'b0;
        end else begin
          v_cur[i] = ($urandom_range(9, 0) < 6);
          d_cur[i] = 8'($urandom);
        end
      end
      full = ($urandom_range(3, 0) == 0);
      r    = ($urandom_range(299, 0) == 0);
      drive_cycle(v_cur, full, r, acc);
    end

    for (int c = 0; c < 2; c++) drive_cycle('0, 1'b0, 1'b0, acc);
    @(negedge clk);
    #1;
    chk("leftover_beats", 32'(bt_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
